// File: rtl/vram_line_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_line_fetcher_if
// Description : Bundles the signals between the scanline fetch sequencer and
//               its surroundings: the video timing generator (line_start_i,
//               line_base_i), the VRAM controller video port (vram_addr_o,
//               vram_data_i), the double-buffered line buffer write side
//               (lb_we_o, lb_bank_o, lb_addr_o, lb_data_o) and status
//               (busy_o, done_o, overrun_o, overrun_clr_i).
//               slave  : the fetcher itself.
//               master : the environment driving and observing the fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_line_fetcher_if #(
    parameter int LB_AW = 7
);
    logic             line_start_i;
    logic [14:0]      line_base_i;
    logic [14:0]      vram_addr_o;
    logic [31:0]      vram_data_i;
    logic             lb_we_o;
    logic             lb_bank_o;
    logic [LB_AW-1:0] lb_addr_o;
    logic [31:0]      lb_data_o;
    logic             busy_o;
    logic             done_o;
    logic             overrun_o;
    logic             overrun_clr_i;

    modport slave (
        input  line_start_i, line_base_i, vram_data_i, overrun_clr_i,
        output vram_addr_o, lb_we_o, lb_bank_o, lb_addr_o, lb_data_o,
               busy_o, done_o, overrun_o
    );

    modport master (
        output line_start_i, line_base_i, vram_data_i, overrun_clr_i,
        input  vram_addr_o, lb_we_o, lb_bank_o, lb_addr_o, lb_data_o,
               busy_o, done_o, overrun_o
    );
endinterface
`default_nettype wire

// File: rtl/vram_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : vram_line_fetcher
// Description : Scanline fetch sequencer. On a line-start pulse it issues
//               WORDS_PER_LINE consecutive VRAM word addresses from the
//               sampled base, captures the read data (one cycle registered
//               latency at the VRAM port) and writes it into the currently
//               selected bank of a double-buffered line buffer.
// Ports       : wb_clk_i   - clock, rising edge
//               wb_reset_i - asynchronous active-low reset
//               bus        - vram_line_fetcher_if.slave (fetch request,
//                            VRAM port, line buffer write port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_line_fetcher #(
    parameter int WORDS_PER_LINE = 80,
    parameter int LB_AW          = 7
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_reset_i,
    vram_line_fetcher_if.slave bus
);

    localparam logic [LB_AW-1:0] c_LAST = LB_AW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [14:0]      r_vram_addr;
    logic [LB_AW-1:0] r_cnt;
    // Read pipeline: r_rd_valid/r_rd_idx describe the word that is on
    // vram_data_i this cycle; the lb_* registers are the second stage.
    logic             r_rd_valid;
    logic [LB_AW-1:0] r_rd_idx;
    logic             r_lb_we;
    logic [LB_AW-1:0] r_lb_addr;
    logic [31:0]      r_lb_data;
    logic             r_bank;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    logic             w_start;
    logic             w_abort;
    logic             w_last_issue;
    logic             w_capture;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_start      = bus.line_start_i;
        w_abort      = bus.line_start_i &&
                       ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
        w_last_issue = (r_cnt == c_LAST);
        // A restart flushes whatever is in flight for the old bank.
        w_capture    = r_rd_valid && !w_abort;
        w_next       = r_state;

        if (w_start) begin
            w_next = ST_ISSUE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_IDLE;
                ST_ISSUE: if (w_last_issue) w_next = ST_DRAIN;
                // The last read has been captured once nothing is
                // left in the first pipeline stage.
                ST_DRAIN: if (!r_rd_valid) w_next = ST_DONE;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Address walk, read pipeline and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            r_vram_addr <= '0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_idx    <= '0;
            r_lb_we     <= 1'b0;
            r_lb_addr   <= '0;
            r_lb_data   <= '0;
            r_bank      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_vram_addr <= bus.line_base_i;
                r_cnt       <= '0;
                r_bank      <= ~r_bank;
            end else if ((r_state == ST_ISSUE) && !w_last_issue) begin
                // 15-bit add wraps 0x7FFF -> 0x0000 naturally.
                r_vram_addr <= r_vram_addr + 15'd1;
                r_cnt       <= r_cnt + LB_AW'(1);
            end

            r_rd_valid <= (r_state == ST_ISSUE) && !w_start;
            r_rd_idx   <= r_cnt;

            r_lb_we <= w_capture;
            if (w_capture) begin
                r_lb_addr <= r_rd_idx;
                r_lb_data <= bus.vram_data_i;
            end

            r_busy <= (w_next == ST_ISSUE) || (w_next == ST_DRAIN);
            r_done <= (w_next == ST_DONE);

            // Set has priority over clear.
            if (w_abort) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.vram_addr_o = r_vram_addr;
    assign bus.lb_we_o     = r_lb_we;
    assign bus.lb_bank_o   = r_bank;
    assign bus.lb_addr_o   = r_lb_addr;
    assign bus.lb_data_o   = r_lb_data;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vram_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_line_fetcher
// Description : Directed bench for vram_line_fetcher. Three instances cover
//               80-word, 4-word and 1-word lines; each VRAM port is modelled
//               with one cycle of registered latency returning word n = n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_line_fetcher;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    vram_line_fetcher_if #(.LB_AW(7)) b80 ();
    vram_line_fetcher_if #(.LB_AW(2)) b4 ();
    vram_line_fetcher_if #(.LB_AW(1)) b1 ();

    vram_line_fetcher #(.WORDS_PER_LINE(80), .LB_AW(7)) u_dut80 (
        .wb_clk_i(clk), .wb_reset_i(rst_n), .bus(b80));
    vram_line_fetcher #(.WORDS_PER_LINE(4), .LB_AW(2)) u_dut4 (
        .wb_clk_i(clk), .wb_reset_i(rst_n), .bus(b4));
    vram_line_fetcher #(.WORDS_PER_LINE(1), .LB_AW(1)) u_dut1 (
        .wb_clk_i(clk), .wb_reset_i(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        b80.vram_data_i <= {17'd0, b80.vram_addr_o};
        b4.vram_data_i  <= {17'd0, b4.vram_addr_o};
        b1.vram_data_i  <= {17'd0, b1.vram_addr_o};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({b80.vram_addr_o, b80.lb_we_o, b80.lb_addr_o, b80.lb_data_o, b80.lb_bank_o,
             b80.busy_o, b80.done_o, b80.overrun_o} !== '0) begin
            n_err++;
            $display("FAIL reset_b80: got addr=%h we=%b la=%h ld=%h bank=%b busy=%b done=%b ovr=%b want all 0",
                     b80.vram_addr_o, b80.lb_we_o, b80.lb_addr_o, b80.lb_data_o,
                     b80.lb_bank_o, b80.busy_o, b80.done_o, b80.overrun_o);
        end
        n_vec++;
        if ({b4.vram_addr_o, b4.lb_we_o, b4.lb_bank_o, b4.busy_o, b4.done_o, b4.overrun_o,
             b1.vram_addr_o, b1.lb_we_o, b1.lb_bank_o, b1.busy_o, b1.done_o} !== '0) begin
            n_err++;
            $display("FAIL reset_small: got b4 addr=%h we=%b b1 addr=%h we=%b want 0",
                     b4.vram_addr_o, b4.lb_we_o, b1.vram_addr_o, b1.lb_we_o);
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({b80.lb_we_o, b80.busy_o, b80.done_o, b80.lb_bank_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got we/busy/done/bank=%b want 0000",
                     {b80.lb_we_o, b80.busy_o, b80.done_o, b80.lb_bank_o});
        end
    endtask

    task automatic test_full_line();
        logic [14:0] exp_addr;
        b80.line_base_i  = 15'h0100;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            if (c <= 82) begin
                exp_addr = (c <= 80) ? 15'(32'h0100 + c - 1) : 15'h014F;
                n_vec++;
                if (b80.vram_addr_o !== exp_addr) begin
                    n_err++;
                    $display("FAIL full_addr c=%0d: got %h want %h", c, b80.vram_addr_o, exp_addr);
                end
            end
            n_vec++;
            if (b80.lb_we_o !== (c >= 3 && c <= 82)) begin
                n_err++;
                $display("FAIL full_we c=%0d: got %b want %b", c, b80.lb_we_o, (c >= 3 && c <= 82));
            end
            if (c >= 3 && c <= 82) begin
                n_vec++;
                if (b80.lb_addr_o !== 7'(c - 3) || b80.lb_data_o !== 32'(32'h0100 + c - 3)) begin
                    n_err++;
                    $display("FAIL full_lb c=%0d: got addr=%h data=%h want addr=%h data=%h", c,
                             b80.lb_addr_o, b80.lb_data_o, 7'(c - 3), 32'(32'h0100 + c - 3));
                end
            end
            n_vec++;
            if (b80.done_o !== (c == 83) || b80.busy_o !== (c <= 82) || b80.lb_bank_o !== 1'b1) begin
                n_err++;
                $display("FAIL full_status c=%0d: got done=%b busy=%b bank=%b want %b %b 1", c,
                         b80.done_o, b80.busy_o, b80.lb_bank_o, (c == 83), (c <= 82));
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp_addr;
        b4.line_base_i  = 15'h7FFE;
        b4.line_start_i = 1'b1;
        step();
        b4.line_start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) begin
                exp_addr = 15'(32'h7FFE + c - 1);
                n_vec++;
                if (b4.vram_addr_o !== exp_addr) begin
                    n_err++;
                    $display("FAIL wrap_addr c=%0d: got %h want %h", c, b4.vram_addr_o, exp_addr);
                end
            end
            n_vec++;
            if (b4.lb_we_o !== (c >= 3 && c <= 6)) begin
                n_err++;
                $display("FAIL wrap_we c=%0d: got %b want %b", c, b4.lb_we_o, (c >= 3 && c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                exp_addr = 15'(32'h7FFE + c - 3);
                n_vec++;
                if (b4.lb_addr_o !== 2'(c - 3) || b4.lb_data_o !== {17'd0, exp_addr}) begin
                    n_err++;
                    $display("FAIL wrap_lb c=%0d: got addr=%h data=%h want addr=%h data=%h", c,
                             b4.lb_addr_o, b4.lb_data_o, 2'(c - 3), {17'd0, exp_addr});
                end
            end
            n_vec++;
            if (b4.done_o !== (c == 7) || b4.busy_o !== (c <= 6) || b4.overrun_o !== 1'b0
                || b4.lb_bank_o !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_status c=%0d: got done=%b busy=%b ovr=%b bank=%b want %b %b 0 1", c,
                         b4.done_o, b4.busy_o, b4.overrun_o, b4.lb_bank_o, (c == 7), (c <= 6));
            end
            step();
        end
    endtask

    task automatic test_single_word();
        b1.line_base_i  = 15'h1234;
        b1.line_start_i = 1'b1;
        step();
        b1.line_start_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3) begin
                n_vec++;
                if (b1.vram_addr_o !== 15'h1234) begin
                    n_err++;
                    $display("FAIL w1_addr c=%0d: got %h want 1234", c, b1.vram_addr_o);
                end
            end
            n_vec++;
            if (b1.lb_we_o !== (c == 3) || b1.done_o !== (c == 4) || b1.busy_o !== (c <= 3)) begin
                n_err++;
                $display("FAIL w1_status c=%0d: got we=%b done=%b busy=%b want %b %b %b", c,
                         b1.lb_we_o, b1.done_o, b1.busy_o, (c == 3), (c == 4), (c <= 3));
            end
            if (c == 3) begin
                n_vec++;
                if (b1.lb_addr_o !== 1'b0 || b1.lb_data_o !== 32'h0000_1234) begin
                    n_err++;
                    $display("FAIL w1_lb: got addr=%h data=%h want 0 00001234", b1.lb_addr_o, b1.lb_data_o);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int we_cnt;
        we_cnt = 0;
        reset_pulse();
        b80.line_base_i  = 15'h0000;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        for (int c = 1; c <= 83; c++) begin
            if (b80.lb_we_o === 1'b1) we_cnt++;
            n_vec++;
            if (b80.done_o !== (c == 83) || b80.lb_bank_o !== 1'b1 || b80.overrun_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_a c=%0d: got done=%b bank=%b ovr=%b want %b 1 0", c,
                         b80.done_o, b80.lb_bank_o, b80.overrun_o, (c == 83));
            end
            if (c == 83) begin
                b80.line_base_i  = 15'h0200;
                b80.line_start_i = 1'b1;
            end
            step();
        end
        b80.line_start_i = 1'b0;
        n_vec++;
        if (we_cnt != 80) begin
            n_err++;
            $display("FAIL b2b_a_writes: got %0d want 80", we_cnt);
        end
        for (int c = 1; c <= 85; c++) begin
            n_vec++;
            if (b80.lb_we_o !== (c >= 3 && c <= 82) || b80.done_o !== (c == 83)
                || b80.lb_bank_o !== 1'b0 || b80.overrun_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_b c=%0d: got we=%b done=%b bank=%b ovr=%b want %b %b 0 0", c,
                         b80.lb_we_o, b80.done_o, b80.lb_bank_o, b80.overrun_o,
                         (c >= 3 && c <= 82), (c == 83));
            end
            if (c >= 3 && c <= 82) begin
                n_vec++;
                if (b80.lb_addr_o !== 7'(c - 3) || b80.lb_data_o !== 32'(32'h0200 + c - 3)) begin
                    n_err++;
                    $display("FAIL b2b_b_lb c=%0d: got addr=%h data=%h want addr=%h data=%h", c,
                             b80.lb_addr_o, b80.lb_data_o, 7'(c - 3), 32'(32'h0200 + c - 3));
                end
            end
            step();
        end
    endtask

    task automatic test_overrun();
        int done_cnt;
        done_cnt = 0;
        b80.line_base_i  = 15'h0300;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (b80.done_o === 1'b1) done_cnt++;
            n_vec++;
            if (b80.lb_we_o !== (c >= 3) || b80.lb_bank_o !== 1'b1 || b80.overrun_o !== 1'b0) begin
                n_err++;
                $display("FAIL ovr_old c=%0d: got we=%b bank=%b ovr=%b want %b 1 0", c,
                         b80.lb_we_o, b80.lb_bank_o, b80.overrun_o, (c >= 3));
            end
            if (c >= 3) begin
                n_vec++;
                if (b80.lb_addr_o !== 7'(c - 3) || b80.lb_data_o !== 32'(32'h0300 + c - 3)) begin
                    n_err++;
                    $display("FAIL ovr_old_lb c=%0d: got addr=%h data=%h want addr=%h data=%h", c,
                             b80.lb_addr_o, b80.lb_data_o, 7'(c - 3), 32'(32'h0300 + c - 3));
                end
            end
            if (c == 40) begin
                b80.line_base_i  = 15'h2000;
                b80.line_start_i = 1'b1;
            end
            step();
        end
        b80.line_start_i = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            if (b80.done_o === 1'b1) done_cnt++;
            n_vec++;
            if (b80.lb_we_o !== (c >= 3 && c <= 82) || b80.done_o !== (c == 83)
                || b80.lb_bank_o !== 1'b0 || b80.overrun_o !== 1'b1) begin
                n_err++;
                $display("FAIL ovr_new c=%0d: got we=%b done=%b bank=%b ovr=%b want %b %b 0 1", c,
                         b80.lb_we_o, b80.done_o, b80.lb_bank_o, b80.overrun_o,
                         (c >= 3 && c <= 82), (c == 83));
            end
            if (c >= 3 && c <= 82) begin
                n_vec++;
                if (b80.lb_addr_o !== 7'(c - 3) || b80.lb_data_o !== 32'(32'h2000 + c - 3)) begin
                    n_err++;
                    $display("FAIL ovr_new_lb c=%0d: got addr=%h data=%h want addr=%h data=%h", c,
                             b80.lb_addr_o, b80.lb_data_o, 7'(c - 3), 32'(32'h2000 + c - 3));
                end
            end
            step();
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL ovr_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_overrun_clr();
        n_vec++;
        if (b80.overrun_o !== 1'b1) begin
            n_err++;
            $display("FAIL clr_sticky: got %b want 1", b80.overrun_o);
        end
        b80.overrun_clr_i = 1'b1;
        step();
        b80.overrun_clr_i = 1'b0;
        n_vec++;
        if (b80.overrun_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_alone: got %b want 0", b80.overrun_o);
        end
        b80.line_base_i  = 15'h0400;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        repeat (9) step();
        n_vec++;
        if (b80.overrun_o !== 1'b0 || b80.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL clr_pre: got ovr=%b busy=%b want 0 1", b80.overrun_o, b80.busy_o);
        end
        b80.line_base_i   = 15'h0500;
        b80.line_start_i  = 1'b1;
        b80.overrun_clr_i = 1'b1;
        step();
        b80.line_start_i  = 1'b0;
        b80.overrun_clr_i = 1'b0;
        n_vec++;
        if (b80.overrun_o !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_set: got %b want 1", b80.overrun_o);
        end
        step();
        n_vec++;
        if (b80.overrun_o !== 1'b1 || b80.vram_addr_o !== 15'h0501) begin
            n_err++;
            $display("FAIL clr_vs_set_hold: got ovr=%b addr=%h want 1 0501", b80.overrun_o, b80.vram_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        b80.line_base_i  = 15'h0600;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        repeat (19) step();
        n_vec++;
        if (b80.lb_we_o !== 1'b1 || b80.lb_addr_o !== 7'd17) begin
            n_err++;
            $display("FAIL mid_pre: got we=%b addr=%h want 1 11", b80.lb_we_o, b80.lb_addr_o);
        end
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({b80.vram_addr_o, b80.lb_we_o, b80.lb_addr_o, b80.lb_data_o, b80.lb_bank_o,
             b80.busy_o, b80.done_o, b80.overrun_o} !== '0) begin
            n_err++;
            $display("FAIL mid_async: got addr=%h we=%b la=%h ld=%h bank=%b busy=%b done=%b ovr=%b want all 0",
                     b80.vram_addr_o, b80.lb_we_o, b80.lb_addr_o, b80.lb_data_o,
                     b80.lb_bank_o, b80.busy_o, b80.done_o, b80.overrun_o);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_vec++;
            if (b80.lb_we_o !== 1'b0 || b80.busy_o !== 1'b0 || b80.done_o !== 1'b0) begin
                n_err++;
                $display("FAIL mid_quiet k=%0d: got we=%b busy=%b done=%b want 0 0 0", c,
                         b80.lb_we_o, b80.busy_o, b80.done_o);
            end
        end
        b80.line_base_i  = 15'h0700;
        b80.line_start_i = 1'b1;
        step();
        b80.line_start_i = 1'b0;
        step();
        step();
        n_vec++;
        if (b80.lb_we_o !== 1'b1 || b80.lb_addr_o !== 7'd0 || b80.lb_data_o !== 32'h0000_0700
            || b80.lb_bank_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_restart: got we=%b addr=%h data=%h bank=%b want 1 00 00000700 1",
                     b80.lb_we_o, b80.lb_addr_o, b80.lb_data_o, b80.lb_bank_o);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        b80.line_start_i = 1'b0; b80.line_base_i = '0; b80.overrun_clr_i = 1'b0;
        b4.line_start_i  = 1'b0; b4.line_base_i  = '0; b4.overrun_clr_i  = 1'b0;
        b1.line_start_i  = 1'b0; b1.line_base_i  = '0; b1.overrun_clr_i  = 1'b0;
        test_reset();
        test_full_line();
        test_wrap();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_overrun_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
